// File: rtl/lite_bus_master.sv
// Xillybus Lite bus initiator: valid/ready commands become single registered wren/rden pulses.
// Writes issue one per cycle; a read holds cmd_ready low until its response is taken on rsp_ready.
module lite_bus_master #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_wstrb,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        user_wren,
  output logic [3:0]  user_wstrb,
  output logic        user_rden,
  output logic [31:0] user_addr,
  output logic [31:0] user_wr_data,
  input  logic [31:0] user_rd_data,
  input  logic        user_irq,
  output logic        irq_pending,
  input  logic        irq_clear,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic        wren;
    logic        rden;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wr_data;
  } bus_t;

  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

  state_t      state, state_nxt;
  bus_t        bus_q, bus_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic        rsp_vld_q, rsp_vld_nxt;
  logic [31:0] rsp_dat_q, rsp_dat_nxt;
  logic        cmd_rdy_q, cmd_rdy_nxt;
  logic        irq_q, irq_pend_q, irq_pend_nxt;
  logic        cmd_fire;
  logic        addr_lsb_unused;

  assign cmd_fire        = cmd_valid & cmd_rdy_q;
  assign addr_lsb_unused = ^cmd_addr[1:0];

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state      <= IDLE;
      bus_q      <= '0;
      cnt_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      cmd_rdy_q  <= 1'b0;
      irq_q      <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus_q      <= bus_nxt;
      cnt_q      <= cnt_nxt;
      rsp_vld_q  <= rsp_vld_nxt;
      rsp_dat_q  <= rsp_dat_nxt;
      cmd_rdy_q  <= cmd_rdy_nxt;
      irq_q      <= user_irq;
      irq_pend_q <= irq_pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus_nxt       = bus_q;
    bus_nxt.wren  = 1'b0;
    bus_nxt.rden  = 1'b0;
    bus_nxt.wstrb = 4'h0;
    cnt_nxt       = cnt_q;
    rsp_vld_nxt   = rsp_vld_q;
    rsp_dat_nxt   = rsp_dat_q;

    case (state)
      IDLE, WR: begin
        state_nxt = IDLE;
        if (cmd_fire) begin
          bus_nxt.addr = {cmd_addr[31:2], 2'b00};
          if (cmd_write) begin
            state_nxt       = WR;
            bus_nxt.wren    = 1'b1;
            bus_nxt.wstrb   = cmd_wstrb;
            bus_nxt.wr_data = cmd_wdata;
          end else begin
            state_nxt    = RD;
            bus_nxt.rden = 1'b1;
          end
        end
      end
      RD: begin
        state_nxt = WAIT;
        cnt_nxt   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_nxt   = RESP;
          rsp_vld_nxt = 1'b1;
          rsp_dat_nxt = user_rd_data;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt   = IDLE;
          rsp_vld_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered ready follows the state we are about to enter, so no input reaches cmd_ready.
  assign cmd_rdy_nxt = (state_nxt == IDLE) || (state_nxt == WR);

  // A fresh rising edge outranks a simultaneous clear; a held-high level cannot re-arm it.
  assign irq_pend_nxt = (user_irq & ~irq_q) ? 1'b1 :
                        irq_clear           ? 1'b0 : irq_pend_q;

  assign cmd_ready    = cmd_rdy_q;
  assign rsp_valid    = rsp_vld_q;
  assign rsp_rdata    = rsp_dat_q;
  assign user_wren    = bus_q.wren;
  assign user_rden    = bus_q.rden;
  assign user_wstrb   = bus_q.wstrb;
  assign user_addr    = bus_q.addr;
  assign user_wr_data = bus_q.wr_data;
  assign irq_pending  = irq_pend_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_lite_bus_master.sv
// Directed bench: RD_LATENCY=1 master against a 32-entry byte-lane register model, plus a RD_LATENCY=3 master.
module tb_lite_bus_master;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic        cmd_valid, cmd_valid3, cmd_write, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        user_irq, irq_clear;

  logic        cmd_ready, rsp_valid, user_wren, user_rden, irq_pending, busy;
  logic [31:0] rsp_rdata, user_addr, user_wr_data, user_rd_data;
  logic [3:0]  user_wstrb;

  logic        cmd_ready3, rsp_valid3, user_wren3, user_rden3, irq_pending3, busy3;
  logic [31:0] rsp_rdata3, user_addr3, user_wr_data3, user_rd_data3;
  logic [3:0]  user_wstrb3;

  int errors = 0;
  int checks = 0;

  always #5 user_clk = ~user_clk;

  lite_bus_master #(.RD_LATENCY(1)) u_dut (
    .user_clk(user_clk), .user_rst(user_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wstrb(cmd_wstrb), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .user_wren(user_wren), .user_wstrb(user_wstrb), .user_rden(user_rden),
    .user_addr(user_addr), .user_wr_data(user_wr_data), .user_rd_data(user_rd_data),
    .user_irq(user_irq), .irq_pending(irq_pending), .irq_clear(irq_clear), .busy(busy)
  );

  lite_bus_master #(.RD_LATENCY(3)) u_dut3 (
    .user_clk(user_clk), .user_rst(user_rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wstrb(cmd_wstrb), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
    .user_wren(user_wren3), .user_wstrb(user_wstrb3), .user_rden(user_rden3),
    .user_addr(user_addr3), .user_wr_data(user_wr_data3), .user_rd_data(user_rd_data3),
    .user_irq(user_irq), .irq_pending(irq_pending3), .irq_clear(irq_clear), .busy(busy3)
  );

  // Register model: read data is valid only in the cycle RD_LATENCY after user_rden.
  logic [31:0] mem [32];
  logic [4:0]  raddr_q = '0;
  logic        rd_pipe = 1'b0;
  logic [31:0] raddr3_q = '0;
  logic [2:0]  rd_pipe3 = '0;
  logic        proto_bad = 1'b0;

  initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;

  always @(posedge user_clk) begin
    rd_pipe  <= user_rden;
    rd_pipe3 <= {rd_pipe3[1:0], user_rden3};
    if (user_rden)  raddr_q  <= user_addr[6:2];
    if (user_rden3) raddr3_q <= user_addr3;
    if (user_wren)
      for (int b = 0; b < 4; b++)
        if (user_wstrb[b]) mem[user_addr[6:2]][b*8 +: 8] <= user_wr_data[b*8 +: 8];
  end

  assign user_rd_data  = rd_pipe     ? mem[raddr_q]              : 32'hDEADBEEF;
  assign user_rd_data3 = rd_pipe3[2] ? (32'hC0DE0000 | raddr3_q) : 32'hDEADBEEF;

  always @(negedge user_clk) begin
    if ((user_wren && user_rden) || (!user_wren && user_wstrb != 4'h0) || user_addr[1:0] != 2'b00)
      proto_bad <= 1'b1;
    if ((user_wren3 && user_rden3) || (!user_wren3 && user_wstrb3 != 4'h0) || user_addr3[1:0] != 2'b00)
      proto_bad <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_wren"}, user_wren, 0);
    check({tag, "_rden"}, user_rden, 0);
    check({tag, "_wstrb"}, user_wstrb, 0);
    check({tag, "_addr"}, user_addr, 0);
    check({tag, "_wr_data"}, user_wr_data, 0);
    check({tag, "_irq_pending"}, irq_pending, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Presents one command and returns #1 after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wstrb = s; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge user_clk);
      n++;
    end while (!cmd_ready && n < 20);
    check("cmd_accept", cmd_ready, 1);
    @(posedge user_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    send(1'b0, a, 4'h0, 32'h0);
    tick();
    tick();
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_rdata, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic stray;
    user_rst = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wstrb = '0; cmd_wdata = '0;
    user_irq = 1'b0; irq_clear = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    check_reset("por");
    user_rst = 1'b0;
    tick();
    check("por_ready", cmd_ready, 1);
    check("por_ready3", cmd_ready3, 1);

    // Single write, then a read through an unaligned address
    send(1'b1, 32'h08, 4'hF, 32'hA5A51234);
    check("wr_wren", user_wren, 1);
    check("wr_addr", user_addr, 32'h08);
    check("wr_data", user_wr_data, 32'hA5A51234);
    check("wr_wstrb", user_wstrb, 4'hF);
    check("wr_rden", user_rden, 0);
    check("wr_busy", busy, 1);
    tick();
    check("wr_end_wren", user_wren, 0);
    check("wr_end_wstrb", user_wstrb, 0);
    check("idle_addr_hold", user_addr, 32'h08);
    check("idle_data_hold", user_wr_data, 32'hA5A51234);
    check("wr_end_busy", busy, 0);

    send(1'b0, 32'h0B, 4'h0, 32'h0);
    check("rd_rden", user_rden, 1);
    check("rd_addr", user_addr, 32'h08);
    check("rd_wren", user_wren, 0);
    check("rd_ready", cmd_ready, 0);
    tick();
    check("rd_n1_rden", user_rden, 0);
    check("rd_n1_valid", rsp_valid, 0);
    tick();
    check("rd_n2_valid", rsp_valid, 1);
    check("rd_n2_data", rsp_rdata, 32'hA5A51234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_done_valid", rsp_valid, 0);
    check("rd_done_busy", busy, 0);
    check("rd_done_ready", cmd_ready, 1);

    // Byte lanes, including a write with no strobes
    send(1'b1, 32'h10, 4'hF, 32'hFFFFFFFF);
    send(1'b1, 32'h10, 4'h5, 32'h00000000);
    send(1'b1, 32'h10, 4'h0, 32'h12345678);
    check("wstrb0_wren", user_wren, 1);
    check("wstrb0_wstrb", user_wstrb, 4'h0);
    tick();
    do_read("lanes", 32'h10, 32'hFF00FF00);

    // Back-to-back writes with cmd_valid held
    cmd_write = 1'b1; cmd_wstrb = 4'hF; cmd_addr = 32'h0; cmd_wdata = 32'h11; cmd_valid = 1'b1;
    @(negedge user_clk);
    check("b2b_ready0", cmd_ready, 1);
    tick();
    check("b2b_wren0", user_wren, 1);
    check("b2b_addr0", user_addr, 32'h0);
    check("b2b_ready1", cmd_ready, 1);
    cmd_addr = 32'h4; cmd_wdata = 32'h22;
    tick();
    check("b2b_wren1", user_wren, 1);
    check("b2b_addr1", user_addr, 32'h4);
    check("b2b_ready2", cmd_ready, 1);
    cmd_addr = 32'h8; cmd_wdata = 32'h33;
    tick();
    check("b2b_wren2", user_wren, 1);
    check("b2b_addr2", user_addr, 32'h8);
    check("b2b_data2", user_wr_data, 32'h33);
    cmd_valid = 1'b0;
    tick();
    check("b2b_end_wren", user_wren, 0);
    do_read("b2b_rd", 32'h4, 32'h22);

    // Response backpressure
    send(1'b0, 32'h4, 4'h0, 32'h0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_rdata, 32'h22);
      check("bp_ready", cmd_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_done_valid", rsp_valid, 0);
    check("bp_done_busy", busy, 0);
    check("bp_done_ready", cmd_ready, 1);

    // RD_LATENCY=3 instance
    cmd_write = 1'b0; cmd_addr = 32'h22; cmd_valid3 = 1'b1;
    @(negedge user_clk);
    check("l3_ready", cmd_ready3, 1);
    tick();
    cmd_valid3 = 1'b0;
    check("l3_rden", user_rden3, 1);
    check("l3_addr", user_addr3, 32'h20);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("l3_early_valid", rsp_valid3, 0);
    end
    tick();
    check("l3_valid", rsp_valid3, 1);
    check("l3_data", rsp_rdata3, 32'hC0DE0020);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("l3_done_valid", rsp_valid3, 0);
    check("l3_done_busy", busy3, 0);

    // Interrupt capture
    check("irq_idle", irq_pending, 0);
    user_irq = 1'b1;
    tick();
    check("irq_set", irq_pending, 1);
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("irq_cleared", irq_pending, 0);
    tick();
    tick();
    check("irq_level_no_reset", irq_pending, 0);
    user_irq = 1'b0;
    tick();
    user_irq = 1'b1; irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("irq_set_beats_clear", irq_pending, 1);

    // Reset in the middle of a read
    send(1'b0, 32'h8, 4'h0, 32'h0);
    tick();
    check("abort_busy", busy, 1);
    user_rst = 1'b1;
    #1;
    check_reset("abort");
    tick();
    user_rst = 1'b0;
    tick();
    check("abort_ready", cmd_ready, 1);
    stray = 1'b0;
    repeat (6) begin
      if (rsp_valid) stray = 1'b1;
      tick();
    end
    check("abort_no_rsp", stray, 0);

    check("protocol_monitor", proto_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
